// File: rtl/spatz_pkg.sv
// Shared Spatz types: instruction IDs, unit responses, execution units.
// Imported by the ID tracker and its testbench.
package spatz_pkg;

  localparam int unsigned NrParallelInstructions = 4;
  localparam int unsigned GPRWidth = 5;
  localparam int unsigned ELEN = 32;

  typedef logic [ELEN-1:0] elen_t;
  typedef logic [$clog2(NrParallelInstructions)-1:0] spatz_id_t;

  typedef enum logic [1:0] {
    CON,
    VFU,
    LSU,
    SLD
  } ex_unit_e;

  typedef struct packed {
    spatz_id_t           id;
    logic [GPRWidth-1:0] rd;
    logic                wb;
    elen_t               result;
  } vfu_rsp_t;

  typedef struct packed {
    spatz_id_t id;
    logic      exc;
  } vlsu_rsp_t;

  typedef struct packed {
    spatz_id_t id;
  } vsldu_rsp_t;

endpackage

// File: rtl/fifo_v3.sv
// Circular FIFO, first-word output. Push is taken while full if a pop
// happens in the same cycle. Ports: push/pop, data in/out, full/empty.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 2,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_empty, bypass;
  logic          do_push, do_pop;

  assign is_empty = (cnt_q == '0);
  assign full_o   = (cnt_q == CW'(DEPTH));
  assign empty_o  = is_empty & ~(FALL_THROUGH & push_i);
  assign data_o   = (FALL_THROUGH && is_empty) ? data_i : mem_q[rd_q];

  // With fall-through, a push into an empty FIFO popped the same cycle
  // never lands in storage.
  assign bypass  = FALL_THROUGH & is_empty & push_i & pop_i;
  assign do_push = push_i & (~full_o | pop_i) & ~bypass;
  assign do_pop  = pop_i & ~is_empty;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = data_i;
      wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=0 gives the index of the lowest
// set bit of in_i; MODE=1 the number of leading zeros. empty_o: in_i==0.
module lzc #(
  parameter int unsigned WIDTH = 2,
  parameter bit          MODE  = 1'b0,
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             empty_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      int j;
      j = MODE ? i : int'(WIDTH) - 1 - i;
      if (in_i[j]) begin
        cnt_o = MODE ? CntW'(int'(WIDTH) - 1 - j) : CntW'(j);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/spatz_id_tracker.sv
// Allocates instruction IDs at issue, frees them on unit completion and
// buffers VFU scalar writebacks for the core. Ports: issue, VFU/VLSU/
// VSLDU completions, writeback handshake, outstanding/busy/err status.
module spatz_id_tracker
  import spatz_pkg::*;
#(
  parameter int unsigned NrIds   = NrParallelInstructions,
  parameter int unsigned WbDepth = 2,
  localparam int unsigned CntW   = $clog2(NrIds + 1),
  localparam int unsigned IdxW   = (NrIds > 1) ? $clog2(NrIds) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  input  ex_unit_e            issue_ex_unit_i,
  output logic                issue_ready_o,
  output spatz_id_t           issue_id_o,
  input  logic                vfu_rsp_valid_i,
  input  vfu_rsp_t            vfu_rsp_i,
  output logic                vfu_rsp_ready_o,
  input  logic                vlsu_rsp_valid_i,
  input  vlsu_rsp_t           vlsu_rsp_i,
  input  logic                vsldu_rsp_valid_i,
  input  vsldu_rsp_t          vsldu_rsp_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [GPRWidth-1:0] wb_rd_o,
  output elen_t               wb_data_o,
  output logic [CntW-1:0]     outstanding_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned WbW = GPRWidth + ELEN;

  logic [NrIds-1:0] in_use_q, in_use_d;
  logic [CntW-1:0]  outst_q, outst_d;
  logic             err_q, err_d;

  logic [IdxW-1:0]  free_idx;
  logic             no_free;
  logic             is_con, alloc;
  logic             vfu_done;
  logic             wb_full, wb_empty;
  logic             wb_push, wb_pop;
  logic [WbW-1:0]   wb_head;

  // Exception flag is reported elsewhere; tracking ignores it.
  logic unused_exc;
  assign unused_exc = vlsu_rsp_i.exc;

  lzc #(
    .WIDTH(NrIds),
    .MODE (1'b0)
  ) i_lzc (
    .in_i   (~in_use_q),
    .cnt_o  (free_idx),
    .empty_o(no_free)
  );

  assign is_con        = (issue_ex_unit_i == CON);
  assign issue_ready_o = is_con | ~no_free;
  assign issue_id_o    = is_con ? '0 : spatz_id_t'(free_idx);
  assign alloc = issue_valid_i & issue_ready_o & ~is_con;

  // A full buffer still accepts when the head leaves this cycle.
  assign wb_pop          = ~wb_empty & wb_ready_i;
  assign vfu_rsp_ready_o = ~vfu_rsp_i.wb | ~wb_full | wb_pop;
  assign vfu_done = vfu_rsp_valid_i & vfu_rsp_ready_o;
  assign wb_push  = vfu_done & vfu_rsp_i.wb;

  fifo_v3 #(
    .FALL_THROUGH(1'b0),
    .DATA_WIDTH  (WbW),
    .DEPTH       (WbDepth)
  ) i_wb_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(1'b0),
    .full_o (wb_full),
    .empty_o(wb_empty),
    .data_i ({vfu_rsp_i.rd, vfu_rsp_i.result}),
    .push_i (wb_push),
    .data_o (wb_head),
    .pop_i  (wb_pop)
  );

  assign wb_valid_o = ~wb_empty;
  assign wb_rd_o    = wb_head[WbW-1 -: GPRWidth];
  assign wb_data_o  = wb_head[ELEN-1:0];

  always_comb begin
    logic [NrIds-1:0] vfu_m, lsu_m, sld_m;
    logic [NrIds-1:0] all_m, dup, set;
    vfu_m = '0;
    lsu_m = '0;
    sld_m = '0;
    set   = '0;
    err_d = err_q;
    if (vfu_done) vfu_m[vfu_rsp_i.id] = 1'b1;
    if (vlsu_rsp_valid_i) lsu_m[vlsu_rsp_i.id] = 1'b1;
    if (vsldu_rsp_valid_i) sld_m[vsldu_rsp_i.id] = 1'b1;
    all_m = vfu_m | lsu_m | sld_m;
    dup = (vfu_m & lsu_m) | (vfu_m & sld_m) | (lsu_m & sld_m);
    // Stray or doubled completions flag an error; the bit ends clear.
    if (|((all_m & ~in_use_q) | dup)) err_d = 1'b1;
    if (alloc) set[free_idx] = 1'b1;
    in_use_d = (in_use_q & ~all_m) | set;
    outst_d = '0;
    for (int i = 0; i < int'(NrIds); i++) begin
      outst_d = outst_d + CntW'(in_use_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      in_use_q <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      in_use_q <= in_use_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
    end
  end

  assign outstanding_o = outst_q;
  assign busy_o        = (outst_q != '0);
  assign err_o         = err_q;

endmodule
